gamepad_sched: RTL and testbench



---
 rtl/gamepad_sched.sv | 221 ++++++++++++++++++++++
 tb/tb_gamepad_sched.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gamepad_sched.sv
// gamepad_sched: frame scheduler in front of the on-demand gamepad scanner.
// It walks every sel/mux slot once per frame over the scanner's go/rdy
// handshake and keeps each 16-bit result in a per-slot shadow register.
// A frame starts on the free-running period timer or on a software pulse.
// Optional macro GAMEPAD_SCHED_CHG_IRQ_EN adds per-slot change flags and an
// interrupt line. When the macro is undefined, chg and irq read as zero.
module gamepad_sched #(
   parameter int SEL_WIDTH = 1,
   parameter int MUX_WIDTH = 1,
   parameter int PERIOD    = 400000,
   parameter int SLOT_BITS = SEL_WIDTH + MUX_WIDTH
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        auto_en,
   input  logic                        sw_trig,
   output logic                        sc_go,
   output logic [SEL_WIDTH-1:0]        sc_sel,
   output logic [MUX_WIDTH-1:0]        sc_mux,
   input  logic                        sc_rdy,
   input  logic [15:0]                 sc_value,
   input  logic [SLOT_BITS-1:0]        rd_addr,
   output logic [15:0]                 rd_data,
   output logic                        busy,
   output logic [7:0]                  frame_cnt,
   output logic [(2**SLOT_BITS)-1:0]   chg,
   input  logic [(2**SLOT_BITS)-1:0]   chg_clr,
   output logic                        irq
);

   localparam int N_SLOTS = 2 ** SLOT_BITS;
   localparam int TMR_W   = (PERIOD > 2) ? $clog2(PERIOD) : 1;
   localparam logic [TMR_W-1:0]     TMR_LAST  = TMR_W'(PERIOD - 1);
   localparam logic [SLOT_BITS-1:0] SLOT_LAST = SLOT_BITS'(N_SLOTS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_LO,
      S_WAIT_HI,
      S_STORE
   } state_t;

   state_t                state_d,   state_q;
   logic [SLOT_BITS-1:0]  slot_d,    slot_q;
   logic [SEL_WIDTH-1:0]  sel_d,     sel_q;
   logic [MUX_WIDTH-1:0]  mux_d,     mux_q;
   logic                  pend_d,    pend_q;
   logic                  busy_d,    busy_q;
   logic [7:0]            frame_d,   frame_q;
   logic [TMR_W-1:0]      tmr_d,     tmr_q;
   logic [15:0]           rd_data_d, rd_data_q;
   logic [15:0]           mem_d [N_SLOTS];
   logic [15:0]           mem_q [N_SLOTS];
   logic                  tmr_trig;
   logic                  trig;
   logic                  wr_en;

   // Period timer: free-runs 0..PERIOD-1 while enabled, parked at 0 otherwise
   always_comb begin
      tmr_trig = auto_en && (tmr_q == TMR_LAST);
      if (!auto_en || tmr_trig) begin
         tmr_d = '0;
      end else begin
         tmr_d = tmr_q + TMR_W'(1);
      end
   end

   // Frame sequencer next-state: trigger/pending arbitration and slot walk
   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      sel_d   = sel_q;
      mux_d   = mux_q;
      pend_d  = pend_q;
      frame_d = frame_q;
      wr_en   = 1'b0;
      trig    = tmr_trig | sw_trig;

      // Triggers arriving mid-frame (including the finishing STORE cycle)
      // collapse into a single pending request.
      if ((state_q != S_IDLE) && trig) begin
         pend_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (trig || pend_q) begin
               pend_d  = 1'b0;
               slot_d  = '0;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            // go is only driven while rdy is high, so rdy here means accepted
            if (sc_rdy) begin
               state_d = S_WAIT_LO;
            end
         end
         S_WAIT_LO: begin
            // skip the stale rdy that was still high in the accept cycle
            if (!sc_rdy) begin
               state_d = S_WAIT_HI;
            end
         end
         S_WAIT_HI: begin
            if (sc_rdy) begin
               state_d = S_STORE;
            end
         end
         S_STORE: begin
            wr_en = 1'b1;
            if (slot_q == SLOT_LAST) begin
               frame_d = frame_q + 8'd1;
               state_d = S_IDLE;
            end else begin
               slot_d  = slot_q + SLOT_BITS'(1);
               state_d = S_ISSUE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // sel/mux are loaded on entry to ISSUE and then held for the scanner
      if ((state_d == S_ISSUE) && (state_q != S_ISSUE)) begin
         sel_d = slot_d[SLOT_BITS-1:MUX_WIDTH];
         mux_d = slot_d[MUX_WIDTH-1:0];
      end

      busy_d = (state_d != S_IDLE);
   end

   // Sequencer and timer registers; reset aborts any frame in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         slot_q  <= '0;
         sel_q   <= '0;
         mux_q   <= '0;
         pend_q  <= 1'b0;
         busy_q  <= 1'b0;
         frame_q <= 8'd0;
         tmr_q   <= '0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         sel_q   <= sel_d;
         mux_q   <= mux_d;
         pend_q  <= pend_d;
         busy_q  <= busy_d;
         frame_q <= frame_d;
         tmr_q   <= tmr_d;
      end
   end

   // Shadow register file write and registered read (old value on a
   // same-cycle write)
   always_comb begin
      mem_d = mem_q;
      if (wr_en) begin
         mem_d[slot_q] = sc_value;
      end
      rd_data_d = mem_q[rd_addr];
   end

   // Shadow register file storage
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_SLOTS; i++) begin
            mem_q[i] <= '0;
         end
         rd_data_q <= '0;
      end else begin
         mem_q     <= mem_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign sc_go     = (state_q == S_ISSUE) && sc_rdy;
   assign sc_sel    = sel_q;
   assign sc_mux    = mux_q;
   assign busy      = busy_q;
   assign frame_cnt = frame_q;
   assign rd_data   = rd_data_q;

`ifdef GAMEPAD_SCHED_CHG_IRQ_EN
   logic [N_SLOTS-1:0] chg_d, chg_q;
   logic               irq_d, irq_q;

   // Change flags: a STORE that alters a slot sets its flag; set beats clear
   always_comb begin
      chg_d = chg_q & ~chg_clr;
      if (wr_en && (sc_value != mem_q[slot_q])) begin
         chg_d[slot_q] = 1'b1;
      end
      irq_d = |chg_d;
   end

   // Change flag and interrupt registers
   always_ff @(posedge clk) begin
      if (rst) begin
         chg_q <= '0;
         irq_q <= 1'b0;
      end else begin
         chg_q <= chg_d;
         irq_q <= irq_d;
      end
   end

   assign chg = chg_q;
   assign irq = irq_q;
`else
   logic unused_chg_clr;
   assign unused_chg_clr = ^chg_clr;
   assign chg = '0;
   assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_gamepad_sched.sv
// tb_gamepad_sched: randomized self-checking bench for gamepad_sched with a
// behavioural scanner and a slot-table reference model.
module tb_gamepad_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        auto_en = 1'b0;
   logic        sw_trig = 1'b0;
   logic        sc_go;
   logic [0:0]  sc_sel;
   logic [0:0]  sc_mux;
   logic        sc_rdy = 1'b1;
   logic [15:0] sc_value = 16'h0000;
   logic [1:0]  rd_addr = 2'd0;
   logic [15:0] rd_data;
   logic        busy;
   logic [7:0]  frame_cnt;
   logic [3:0]  chg;
   logic [3:0]  chg_clr = 4'd0;
   logic        irq;

   int checks = 0;
   int errors = 0;

   // scanner model state
   logic [15:0] scan_tab [4];
   int          lat = 2;
   bit          scan_hold = 1'b0;
   int          cnt = 0;
   logic [1:0]  go_log [$];

   // reference model
   logic [15:0] exp_mem [4];
   logic [7:0]  exp_fc = 8'd0;

   gamepad_sched #(
      .SEL_WIDTH(1),
      .MUX_WIDTH(1),
      .PERIOD(100)
   ) dut (
      .clk(clk),
      .rst(rst),
      .auto_en(auto_en),
      .sw_trig(sw_trig),
      .sc_go(sc_go),
      .sc_sel(sc_sel),
      .sc_mux(sc_mux),
      .sc_rdy(sc_rdy),
      .sc_value(sc_value),
      .rd_addr(rd_addr),
      .rd_data(rd_data),
      .busy(busy),
      .frame_cnt(frame_cnt),
      .chg(chg),
      .chg_clr(chg_clr),
      .irq(irq)
   );

   always #5 clk = ~clk;

   // Scanner: accepts go while ready, drops rdy, returns value after lat cycles
   always @(posedge clk) begin
      if (sc_go && sc_rdy) begin
         go_log.push_back({sc_sel, sc_mux});
         sc_value <= scan_tab[{sc_sel, sc_mux}];
         sc_rdy   <= 1'b0;
         cnt      <= lat;
      end else if (scan_hold) begin
         sc_rdy <= 1'b0;
      end else if (!sc_rdy) begin
         if (cnt == 0) sc_rdy <= 1'b1;
         else          cnt    <= cnt - 1;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation time exceeded");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) exp_mem[i] = 16'h0000;
      exp_fc = 8'd0;
   endtask

   task automatic pulse_trig();
      sw_trig = 1'b1;
      tick();
      sw_trig = 1'b0;
   endtask

   task automatic wait_fc(input logic [7:0] target, input int maxc, input string nm);
      int n;
      n = 0;
      while ((frame_cnt !== target) && (n < maxc)) begin
         tick();
         n++;
      end
      tick();
      checks++;
      if (frame_cnt !== target) begin
         errors++;
         $display("FAIL %s frame_cnt timeout: got %0d want %0d", nm, frame_cnt, target);
      end
   endtask

   task automatic wait_gos(input int want, input int maxc, input string nm);
      int n;
      n = 0;
      while ((go_log.size() < want) && (n < maxc)) begin
         tick();
         n++;
      end
      checks++;
      if (go_log.size() < want) begin
         errors++;
         $display("FAIL %s go timeout: got %0d want %0d", nm, go_log.size(), want);
      end
   endtask

   task automatic wait_rdy(input int maxc, input string nm);
      int n;
      n = 0;
      while (!sc_rdy && (n < maxc)) begin
         tick();
         n++;
      end
      checks++;
      if (!sc_rdy) begin
         errors++;
         $display("FAIL %s rdy timeout", nm);
      end
   endtask

   task automatic check_mem(input string nm);
      for (int i = 0; i < 4; i++) begin
         rd_addr = 2'(i);
         tick();
         checks++;
         if (rd_data !== exp_mem[i]) begin
            errors++;
            $display("FAIL %s slot%0d: got %h want %h", nm, i, rd_data, exp_mem[i]);
         end
      end
   endtask

   task automatic check_gos(input int first, input int n, input string nm);
      checks++;
      if (go_log.size() - first != n) begin
         errors++;
         $display("FAIL %s go count: got %0d want %0d", nm, go_log.size() - first, n);
      end else begin
         for (int k = 0; k < n; k++) begin
            checks++;
            if (go_log[first + k] !== 2'(k % 4)) begin
               errors++;
               $display("FAIL %s go%0d sel/mux: got %b want %b", nm, k, go_log[first + k], 2'(k % 4));
            end
         end
      end
   endtask

   task automatic check_fc(input string nm);
      checks++;
      if (frame_cnt !== exp_fc) begin
         errors++;
         $display("FAIL %s frame_cnt: got %0d want %0d", nm, frame_cnt, exp_fc);
      end
   endtask

   task automatic rand_tab();
      for (int i = 0; i < 4; i++) scan_tab[i] = 16'($urandom);
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({busy, sc_go, sc_sel, sc_mux} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_ctrl busy/go/sel/mux: got %b want 0000", {busy, sc_go, sc_sel, sc_mux});
      end
      check_fc("reset");
      checks++;
      if ({chg, irq} !== 5'b0) begin
         errors++;
         $display("FAIL reset_chg chg/irq: got %b want 00000", {chg, irq});
      end
      check_mem("reset");
   endtask

   task automatic test_single_frame();
      int start;
      for (int i = 0; i < 4; i++) scan_tab[i] = 16'h0A00 + 16'(i);
      lat = 3;
      start = go_log.size();
      pulse_trig();
      exp_fc = exp_fc + 8'd1;
      wait_fc(exp_fc, 500, "single");
      for (int i = 0; i < 4; i++) exp_mem[i] = scan_tab[i];
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL single busy after frame: got %b want 0", busy);
      end
      check_gos(start, 4, "single");
      check_mem("single");
      check_fc("single");
   endtask

   task automatic test_pending();
      int start;
      rand_tab();
      lat = 6;
      start = go_log.size();
      pulse_trig();
      for (int j = 0; j < 3; j++) begin
         repeat (5) tick();
         pulse_trig();
      end
      exp_fc = exp_fc + 8'd2;
      wait_fc(exp_fc, 1000, "pending");
      for (int i = 0; i < 4; i++) exp_mem[i] = scan_tab[i];
      repeat (80) tick();
      check_gos(start, 8, "pending");
      check_fc("pending");
      check_mem("pending");
   endtask

   task automatic test_back_to_back();
      int start;
      rand_tab();
      lat = 4;
      start = go_log.size();
      pulse_trig();
      wait_gos(start + 4, 500, "b2b");
      wait_rdy(100, "b2b");
      tick();
      // sequencer is now in the final STORE cycle
      pulse_trig();
      exp_fc = exp_fc + 8'd2;
      wait_fc(exp_fc, 1000, "b2b");
      for (int i = 0; i < 4; i++) exp_mem[i] = scan_tab[i];
      repeat (40) tick();
      check_gos(start, 8, "b2b");
      check_fc("b2b");
   endtask

   task automatic test_random_frames();
      int start;
      for (int f = 0; f < 3; f++) begin
         rand_tab();
         lat = $urandom_range(0, 5);
         start = go_log.size();
         pulse_trig();
         exp_fc = exp_fc + 8'd1;
         wait_fc(exp_fc, 500, "random");
         for (int i = 0; i < 4; i++) exp_mem[i] = scan_tab[i];
         check_gos(start, 4, "random");
         check_mem("random");
      end
   endtask

   task automatic test_period();
      int   rises [$];
      logic prev;
      rand_tab();
      lat = 20;
      auto_en = 1'b1;
      prev = busy;
      for (int k = 1; k <= 398; k++) begin
         tick();
         if (busy && !prev) rises.push_back(k);
         prev = busy;
      end
      auto_en = 1'b0;
      exp_fc = exp_fc + 8'd3;
      for (int i = 0; i < 4; i++) exp_mem[i] = scan_tab[i];
      tick();
      checks++;
      if (rises.size() != 3) begin
         errors++;
         $display("FAIL period frame starts: got %0d want 3", rises.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (rises[i] != 100 * (i + 1)) begin
               errors++;
               $display("FAIL period start%0d cycle: got %0d want %0d", i, rises[i], 100 * (i + 1));
            end
         end
      end
      check_fc("period");
      check_mem("period");
   endtask

   task automatic test_reset_mid();
      int start;
      rand_tab();
      lat = 20;
      start = go_log.size();
      pulse_trig();
      wait_gos(start + 3, 500, "rstmid");
      repeat (8) tick();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) exp_mem[i] = 16'h0000;
      exp_fc = 8'd0;
      checks++;
      if ({busy, sc_go} !== 2'b00) begin
         errors++;
         $display("FAIL rstmid busy/go: got %b want 00", {busy, sc_go});
      end
      check_fc("rstmid");
      check_mem("rstmid");
      start = go_log.size();
      repeat (40) tick();
      checks++;
      if (go_log.size() != start) begin
         errors++;
         $display("FAIL rstmid spurious go: got %0d want 0", go_log.size() - start);
      end
      pulse_trig();
      exp_fc = exp_fc + 8'd1;
      wait_fc(exp_fc, 500, "rstmid");
      for (int i = 0; i < 4; i++) exp_mem[i] = scan_tab[i];
      check_gos(start, 4, "rstmid");
      check_mem("rstmid_after");
   endtask

   task automatic test_rdy_stall();
      int start;
      int bad;
      rand_tab();
      lat = 2;
      scan_hold = 1'b1;
      do_reset();
      start = go_log.size();
      bad = 0;
      for (int k = 0; k < 50; k++) begin
         if (k == 10) sw_trig = 1'b1;
         tick();
         sw_trig = 1'b0;
         if (sc_go !== 1'b0 || sc_sel !== 1'b0 || sc_mux !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL stall go/sel/mux bad cycles: got %0d busy %b want 0 busy 1", bad, busy);
      end
      scan_hold = 1'b0;
      exp_fc = exp_fc + 8'd1;
      wait_fc(exp_fc, 500, "stall");
      for (int i = 0; i < 4; i++) exp_mem[i] = scan_tab[i];
      check_gos(start, 4, "stall");
      check_mem("stall");
   endtask

   task automatic test_chg();
`ifdef GAMEPAD_SCHED_CHG_IRQ_EN
      logic [3:0] exp_chg;
      int         start;
      do_reset();
      lat = 2;
      for (int i = 0; i < 4; i++) scan_tab[i] = 16'h0000;
      scan_tab[1] = 16'h0001;
      exp_chg = 4'b0000;
      for (int i = 0; i < 4; i++) if (scan_tab[i] != exp_mem[i]) exp_chg[i] = 1'b1;
      pulse_trig();
      exp_fc = exp_fc + 8'd1;
      wait_fc(exp_fc, 500, "chg1");
      for (int i = 0; i < 4; i++) exp_mem[i] = scan_tab[i];
      tick();
      checks++;
      if ({chg, irq} !== {exp_chg, |exp_chg}) begin
         errors++;
         $display("FAIL chg1 chg/irq: got %b/%b want %b/%b", chg, irq, exp_chg, |exp_chg);
      end
      chg_clr = 4'b0010;
      tick();
      chg_clr = 4'b0000;
      tick();
      checks++;
      if ({chg, irq} !== 5'b00000) begin
         errors++;
         $display("FAIL chg_clear chg/irq: got %b/%b want 0000/0", chg, irq);
      end
      scan_tab[1] = 16'h0002;
      start = go_log.size();
      pulse_trig();
      wait_gos(start + 2, 200, "chg2");
      wait_rdy(100, "chg2");
      tick();
      // slot 1 is being stored this cycle
      chg_clr = 4'b0010;
      tick();
      chg_clr = 4'b0000;
      exp_fc = exp_fc + 8'd1;
      wait_fc(exp_fc, 500, "chg2");
      for (int i = 0; i < 4; i++) exp_mem[i] = scan_tab[i];
      tick();
      checks++;
      if ({chg, irq} !== 5'b00101) begin
         errors++;
         $display("FAIL chg_setwins chg/irq: got %b/%b want 0010/1", chg, irq);
      end
      check_mem("chg2");
`else
      int bad;
      int n;
      do_reset();
      rand_tab();
      lat = 1;
      bad = 0;
      pulse_trig();
      n = 0;
      while (busy && n < 500) begin
         chg_clr = 4'($urandom);
         tick();
         if ({chg, irq} !== 5'b0) bad++;
         n++;
      end
      chg_clr = 4'b0000;
      exp_fc = exp_fc + 8'd1;
      wait_fc(exp_fc, 500, "nochg");
      checks++;
      if (bad != 0 || {chg, irq} !== 5'b0) begin
         errors++;
         $display("FAIL nochg chg/irq nonzero cycles: got %0d want 0", bad);
      end
`endif
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_single_frame();
      test_pending();
      test_back_to_back();
      test_random_frames();
      test_period();
      test_reset_mid();
      test_rdy_stall();
      test_chg();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
